// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: sole bus master of a single-port RAM. Turns a valid/ready
// request stream into cs/we/addr strobes, owns the bidirectional data bus and
// returns exactly one response (read data or write ack, plus error) per request.
module ram_req_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    inout  wire  [DATA_W-1:0] ram_data_io,
    output logic [CNT_W-1:0]  wr_cnt_o,
    output logic [CNT_W-1:0]  rd_cnt_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;
    localparam logic [2:0] S_RSP  = 3'd5;

    // DEPTH may equal 2**ADDR_W, so the bound needs one extra bit
    localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic              w_accept;
    logic              w_addr_bad;

    assign w_accept   = (r_state == S_IDLE) && req_valid_i;
    assign w_addr_bad = ({1'b0, req_addr_i} >= DEPTH_V);

    // Transaction sequencing: one request in flight, RSP waits for the consumer
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (w_addr_bad)
                            r_state <= S_ERR;
                        else if (req_we_i)
                            r_state <= S_WR;
                        else
                            r_state <= S_RD;
                    end
                end
                S_WR:    r_state <= S_RSP;
                S_RD:    r_state <= S_CAP;
                S_CAP:   r_state <= S_RSP;
                S_ERR:   r_state <= S_RSP;
                S_RSP: begin
                    if (rsp_ready_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Latch the accepted request so the source may change its inputs afterwards
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
        end
    end

    // Build the response payload on the edge that enters RSP
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_WR: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                S_CAP: begin
                    r_rdata <= ram_data_io;
                    r_err   <= 1'b0;
                end
                S_ERR: begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
                default: begin
                    r_rdata <= r_rdata;
                    r_err   <= r_err;
                end
            endcase
        end
    end

    // Count completed RAM cycles; errors never touch the RAM so never count
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (r_state == S_WR)
                r_wr_cnt <= r_wr_cnt + 1'b1;
            if (r_state == S_CAP)
                r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end

    // Ready is masked by reset so it reads 0 while reset is held
    assign req_ready_o = rst_n_i && (r_state == S_IDLE);
    assign rsp_valid_o = (r_state == S_RSP);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
    assign ram_cs_o    = (r_state == S_WR) || (r_state == S_RD);
    assign ram_we_o    = (r_state == S_WR);
    assign ram_addr_o  = r_addr;
    // The bus is driven only during WR; the RAM owns it in the CAP cycle
    assign ram_data_io = (r_state == S_WR) ? r_wdata : {DATA_W{1'bz}};
    assign wr_cnt_o    = r_wr_cnt;
    assign rd_cnt_o    = r_rd_cnt;

endmodule
